// File: rtl/duty_selector_pkg.sv
// Shared types and constants for the duty-code selector.
package duty_selector_pkg;

  localparam int unsigned OpcW = 3;

  localparam logic [OpcW-1:0] MinLevel = 3'd0;
  localparam logic [OpcW-1:0] MaxLevel = 3'd6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD_UP = 2'd1,
    HOLD_DN = 2'd2,
    LOCK    = 2'd3
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for one raw pushbutton.
module btn_debounce #(
  parameter int unsigned DebounceCycles = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic db_o
);

  localparam int unsigned CntW = $clog2(DebounceCycles);

  logic            sync1_q, sync2_q;
  logic            db_q, db_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Any agreeing sample restarts the count, so only a run of
  // DebounceCycles mismatching samples flips the debounced state.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CntW'(DebounceCycles - 1)) db_d = ~db_q;
      else                                    cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/duty_selector.sv
// Up/down pushbutton duty-code selector with auto-repeat and both-pressed lockout.
module duty_selector
  import duty_selector_pkg::*;
#(
  parameter int unsigned DebounceCycles = 1000000,
  parameter int unsigned RepeatCycles   = 25000000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            btn_up_i,
  input  logic            btn_dn_i,
  output logic [OpcW-1:0] opc_o,
  output logic            chg_o
);

  localparam int unsigned RptW = $clog2(RepeatCycles);

  logic            up_db, dn_db;
  logic            up_prev_q, dn_prev_q;
  logic            up_rise, dn_rise;
  state_e          state_q, state_d;
  logic [RptW-1:0] rpt_q, rpt_d;
  logic [OpcW-1:0] opc_q, opc_d;
  logic            chg_q, chg_d;
  logic            step_up, step_dn;

  btn_debounce #(.DebounceCycles(DebounceCycles)) u_up (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .btn_i (btn_up_i),
    .db_o  (up_db)
  );

  btn_debounce #(.DebounceCycles(DebounceCycles)) u_dn (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .btn_i (btn_dn_i),
    .db_o  (dn_db)
  );

  assign up_rise = up_db & ~up_prev_q;
  assign dn_rise = dn_db & ~dn_prev_q;

  always_comb begin
    state_d = state_q;
    rpt_d   = rpt_q;
    step_up = 1'b0;
    step_dn = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((up_rise && dn_db) || (dn_rise && up_db)) begin
          state_d = LOCK;
        end else if (up_rise) begin
          step_up = 1'b1;
          state_d = HOLD_UP;
        end else if (dn_rise) begin
          step_dn = 1'b1;
          state_d = HOLD_DN;
        end
      end
      HOLD_UP: begin
        if (!up_db)                               state_d = IDLE;
        else if (dn_db)                           state_d = LOCK;
        else if (rpt_q == RptW'(RepeatCycles - 1)) begin
          rpt_d   = '0;
          step_up = 1'b1;
        end else                                  rpt_d = rpt_q + 1'b1;
      end
      HOLD_DN: begin
        if (!dn_db)                               state_d = IDLE;
        else if (up_db)                           state_d = LOCK;
        else if (rpt_q == RptW'(RepeatCycles - 1)) begin
          rpt_d   = '0;
          step_dn = 1'b1;
        end else                                  rpt_d = rpt_q + 1'b1;
      end
      LOCK: begin
        if (!up_db && !dn_db) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) rpt_d = '0;
  end

  // Steps at the limits are swallowed, so chg_o only marks real code changes.
  always_comb begin
    opc_d = opc_q;
    if (step_up && (opc_q < MaxLevel))      opc_d = opc_q + 1'b1;
    else if (step_dn && (opc_q > MinLevel)) opc_d = opc_q - 1'b1;
    chg_d = (opc_d != opc_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rpt_q     <= '0;
      opc_q     <= MinLevel;
      chg_q     <= 1'b0;
      up_prev_q <= 1'b0;
      dn_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rpt_q     <= rpt_d;
      opc_q     <= opc_d;
      chg_q     <= chg_d;
      up_prev_q <= up_db;
      dn_prev_q <= dn_db;
    end
  end

  assign opc_o = opc_q;
  assign chg_o = chg_q;

endmodule

// File: tb/tb_duty_selector.sv
// Directed bench for duty_selector with DebounceCycles=4, RepeatCycles=16.
module tb_duty_selector;
  import duty_selector_pkg::*;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            btn_up_i;
  logic            btn_dn_i;
  logic [OpcW-1:0] opc_o;
  logic            chg_o;

  int checks = 0;
  int errors = 0;
  int pulses;

  duty_selector #(.DebounceCycles(4), .RepeatCycles(16)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .btn_up_i (btn_up_i),
    .btn_dn_i (btn_dn_i),
    .opc_o    (opc_o),
    .chg_o    (chg_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  // Advance n cycles, counting how many of them show chg_o high.
  task automatic run_cnt(input int n, output int p);
    p = 0;
    repeat (n) begin
      tick(1);
      if (chg_o === 1'b1) p++;
    end
  endtask

  task automatic do_reset();
    btn_up_i = 1'b0;
    btn_dn_i = 1'b0;
    rst_i    = 1'b1;
    tick(2);
    rst_i    = 1'b0;
    tick(1);
  endtask

  // Press long enough for one step (at cycle 7), release, and let the FSM settle.
  task automatic tap_up();
    btn_up_i = 1'b1;
    tick(8);
    btn_up_i = 1'b0;
    tick(10);
  endtask

  initial begin
    btn_up_i = 1'b0;
    btn_dn_i = 1'b0;
    rst_i    = 1'b1;
    tick(2);
    chk("reset_opc", int'(opc_o), 0);
    chk("reset_chg", int'(chg_o), 0);
    chk("reset_state", int'(dut.state_q), int'(IDLE));
    rst_i = 1'b0;
    tick(1);

    // Clean press held 10 cycles: one step at cycle 7.
    btn_up_i = 1'b1;
    tick(6);
    chk("clean_c6_opc", int'(opc_o), 0);
    chk("clean_c6_chg", int'(chg_o), 0);
    tick(1);
    chk("clean_c7_opc", int'(opc_o), 1);
    chk("clean_c7_chg", int'(chg_o), 1);
    tick(1);
    chk("clean_c8_chg", int'(chg_o), 0);
    tick(2);
    btn_up_i = 1'b0;
    run_cnt(12, pulses);
    chk("clean_no_more_steps", pulses, 0);
    chk("clean_final_opc", int'(opc_o), 1);

    // Glitch of 3 cycles is shorter than the debounce window.
    btn_up_i = 1'b1;
    tick(3);
    btn_up_i = 1'b0;
    run_cnt(12, pulses);
    chk("glitch_pulses", pulses, 0);
    chk("glitch_opc", int'(opc_o), 1);

    // Bouncing 1-0-1-0 in 2-cycle phases then steady high: exactly one step.
    do_reset();
    chk("bounce_start_opc", int'(opc_o), 0);
    for (int i = 0; i < 4; i++) begin
      btn_up_i = ~i[0];
      tick(2);
    end
    btn_up_i = 1'b1;
    run_cnt(14, pulses);
    chk("bounce_pulses", pulses, 1);
    chk("bounce_opc", int'(opc_o), 1);
    btn_up_i = 1'b0;
    tick(10);

    // Saturation at the top: held at 5 for 40 cycles.
    do_reset();
    repeat (5) tap_up();
    chk("sat_hi_start", int'(opc_o), 5);
    btn_up_i = 1'b1;
    run_cnt(40, pulses);
    chk("sat_hi_pulses", pulses, 1);
    chk("sat_hi_opc", int'(opc_o), 6);
    btn_up_i = 1'b0;
    tick(10);
    chk("sat_hi_after", int'(opc_o), 6);

    // Down auto-repeat from 3 at 16-cycle spacing, saturating at 0.
    do_reset();
    repeat (3) tap_up();
    chk("rep_dn_start", int'(opc_o), 3);
    btn_dn_i = 1'b1;
    tick(7);
    chk("rep_dn_c7_opc", int'(opc_o), 2);
    chk("rep_dn_c7_chg", int'(chg_o), 1);
    tick(15);
    chk("rep_dn_c22_opc", int'(opc_o), 2);
    chk("rep_dn_c22_chg", int'(chg_o), 0);
    tick(1);
    chk("rep_dn_c23_opc", int'(opc_o), 1);
    chk("rep_dn_c23_chg", int'(chg_o), 1);
    tick(16);
    chk("rep_dn_c39_opc", int'(opc_o), 0);
    chk("rep_dn_c39_chg", int'(chg_o), 1);
    run_cnt(40, pulses);
    chk("sat_lo_pulses", pulses, 0);
    chk("sat_lo_opc", int'(opc_o), 0);
    btn_dn_i = 1'b0;
    tick(10);

    // Both pressed together: lockout until both released.
    do_reset();
    repeat (2) tap_up();
    chk("lock_start", int'(opc_o), 2);
    btn_up_i = 1'b1;
    btn_dn_i = 1'b1;
    run_cnt(10, pulses);
    chk("lock_both_pulses", pulses, 0);
    chk("lock_both_state", int'(dut.state_q), int'(LOCK));
    btn_up_i = 1'b0;
    run_cnt(30, pulses);
    chk("lock_dn_only_pulses", pulses, 0);
    chk("lock_dn_only_state", int'(dut.state_q), int'(LOCK));
    chk("lock_dn_only_opc", int'(opc_o), 2);
    btn_dn_i = 1'b0;
    tick(10);
    chk("lock_release_state", int'(dut.state_q), int'(IDLE));
    tap_up();
    chk("lock_after_tap", int'(opc_o), 3);

    // Reset in the middle of a hold at level 4.
    do_reset();
    repeat (3) tap_up();
    btn_up_i = 1'b1;
    tick(12);
    chk("rst_mid_pre_opc", int'(opc_o), 4);
    rst_i = 1'b1;
    #1;
    chk("rst_mid_async_opc", int'(opc_o), 0);
    chk("rst_mid_async_chg", int'(chg_o), 0);
    #1;
    rst_i = 1'b0;
    tick(6);
    chk("rst_mid_c6_opc", int'(opc_o), 0);
    tick(1);
    chk("rst_mid_c7_opc", int'(opc_o), 1);
    chk("rst_mid_c7_chg", int'(chg_o), 1);
    btn_up_i = 1'b0;
    tick(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/duty_selector.md
DUTY_SELECTOR -- requirements
Module: duty_selector

Interface
REQ-001 Parameter DebounceCycles, default 1000000, SHALL set the consecutive stable cycles needed to accept a button change (20 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 Parameter RepeatCycles, default 25000000, SHALL set the hold time before each auto-repeat step (0.5 s at 50 MHz); legal range 2..2^26-1.
REQ-003 clk_i  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 btn_up_i  input  1  raw, bouncing, asynchronous "increase duty" pushbutton, active-high.
REQ-006 btn_dn_i  input  1  raw, bouncing, asynchronous "decrease duty" pushbutton, active-high.
REQ-007 opc_o  output  3  registered duty code for the downstream PWM counter: 0 = 0%, 1..5 = 5/10/25/50/75%, 6 = 100%.
REQ-008 chg_o  output  1  registered one-cycle pulse, high in the same cycle opc_o takes a new value.

Function
REQ-009 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-010 Debounce: a per-button counter SHALL increment while the synchronized input differs from the debounced state and SHALL clear on any cycle they agree.
REQ-011 The debounced state SHALL toggle, and the counter clear, on the edge where the counter reaches DebounceCycles-1, i.e. after DebounceCycles consecutive mismatching samples.
REQ-012 Pad-to-debounced latency SHALL be exactly DebounceCycles+2 cycles for a clean edge; glitches shorter than DebounceCycles cycles SHALL produce no change.
REQ-013 Control FSM states: IDLE, HOLD_UP, HOLD_DN, LOCK.
REQ-014 IDLE: debounced up rising with down low -> step +1, go HOLD_UP; debounced down rising with up low -> step -1, go HOLD_DN; both high in the same cycle -> no step, go LOCK.
REQ-015 HOLD_UP/HOLD_DN: repeat timer SHALL count while the button stays held; at RepeatCycles-1 it SHALL clear and issue another step in the same direction.
REQ-016 HOLD_UP/HOLD_DN: release of the held button -> IDLE; assertion of the opposite button -> LOCK, no step.
REQ-017 LOCK: SHALL issue no steps and SHALL return to IDLE only when both debounced buttons are low.
REQ-018 The level SHALL saturate at 0 and 6; code 7 SHALL never be produced.
REQ-019 A step at a saturation limit SHALL leave opc_o unchanged and keep chg_o low.
REQ-020 opc_o and chg_o SHALL update on the clock edge after the debounced edge or repeat expiry that caused the step (1-cycle latency).
REQ-021 The repeat timer SHALL clear on every FSM state change.

Reset
REQ-022 On rst_i high, asynchronously: opc_o = 0, chg_o = 0, FSM = IDLE, synchronizers, debounced states and all counters = 0.
REQ-023 Reset asserted mid-press SHALL abort the press; after release of reset, a still-held button SHALL be treated as a new press once debounced (DebounceCycles+2 cycles).

Structure
REQ-024 A shared package SHALL hold the FSM state encoding, the constants MinLevel = 0 and MaxLevel = 6, and the duty-code width (3).
REQ-025 The synchronizer plus debouncer SHALL be one sub-module, btn_debounce, instantiated once per button.
REQ-026 Counter widths SHALL be derived from the parameters via $clog2.

Verification (DebounceCycles = 4, RepeatCycles = 16)
REQ-027 Clean up press held 10 cycles -> debounced high at cycle 6, opc_o 0->1 with a chg_o pulse at cycle 7, no further step.
REQ-028 Up input bouncing 1-0-1-0 with 2-cycle periods, then steady -> exactly one step, opc_o = 1.
REQ-029 Up held at opc_o = 5 for 40 cycles -> opc_o 6 once; later repeat expiries give no chg_o; opc_o stays 6.
REQ-030 Down held from opc_o = 3 -> 2, then repeats at 16-cycle spacing to 1, then 0, then stays 0.
REQ-031 Up and down pressed on the same cycle, then up released while down held -> no step, FSM stays LOCK until both released.
REQ-032 rst_i pulsed mid-hold at opc_o = 4 -> opc_o = 0 immediately; the held button then steps to 1 after DebounceCycles+3 cycles.
